hart_sequencer: RTL

Multi-cycle control FSM for the RV32I core datapath (ALU, program counter, register file, ALU input muxes).
- Fetches an instruction over a request/valid handshake and latches it into an internal instruction register (IR).
- Decodes the IR and steps it through DECODE/EXECUTE/MEMORY/WRITEBACK, driving every datapath select and enable.
- Sits inside core, between the instruction/data memory interfaces and the datapath.

---
 rtl/rv32i_pkg.sv | 76 +++++++
 rtl/imm_gen.sv | 26 ++
 rtl/hart_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I opcode constants, control enums and decode helpers for the
// multi-cycle hart sequencer.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_ALU   = 2'b10
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_IMM  = 2'b11
  } wb_sel_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } seq_state_t;

  // SYSTEM (ECALL/EBREAK/CSR) is deliberately absent: it traps.
  function automatic logic is_legal_opcode(input logic [6:0] i_opc);
    case (i_opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic alu_op_t alu_from_funct(input logic [2:0] i_funct3,
                                             input logic       i_funct7b5,
                                             input logic       i_allow_sub);
    case (i_funct3)
      3'b000:  return (i_funct7b5 && i_allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return i_funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction (I/S/B/U/J) chosen by the IR opcode,
// sign-extended to the datapath width.
module imm_gen
  import rv32i_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [31:0]       i_ir,
  output logic [DWIDTH-1:0] o_imm
);

  logic [31:0] w_imm32;

  always_comb begin
    case (i_ir[6:0])
      OPC_STORE:          w_imm32 = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
      OPC_BRANCH:         w_imm32 = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: w_imm32 = {i_ir[31:12], 12'b0};
      OPC_JAL:            w_imm32 = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
      default:            w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
    endcase
  end

  assign o_imm = DWIDTH'($signed(w_imm32));

endmodule

// File: rtl/hart_sequencer.sv
// Multi-cycle RV32I control FSM: fetches into the IR, then walks each instruction
// through DECODE/EXECUTE/MEMORY/WRITEBACK driving the datapath selects and strobes.
module hart_sequencer
  import rv32i_pkg::*;
#(
  parameter int          DWIDTH   = 32,
  parameter logic [31:0] RESET_IR = 32'h0000_0013
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core_N,
  output logic              Instr_Req,
  input  logic              Instr_Valid,
  input  logic [31:0]       Instruction,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [2:0]        Mem_Size,
  input  logic              Mem_Ack,
  input  logic              ALU_Zero_Flag,
  output logic [3:0]        ALU_OP,
  output logic              ALU_Src_A_Sel,
  output logic              ALU_Src_B_Sel,
  output logic [1:0]        PC_Sel,
  output logic              PC_Write,
  output logic [4:0]        Rs1_Addr,
  output logic [4:0]        Rs2_Addr,
  output logic [4:0]        Rd_Addr,
  output logic [DWIDTH-1:0] Imm,
  output logic              Reg_Wr_En,
  output logic [1:0]        Wb_Sel,
  output logic              Illegal_Instr
);

  seq_state_t  r_state;
  logic [31:0] r_ir;
  logic        r_illegal;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_funct7b5;
  logic        w_is_store;
  logic        w_branch_taken;
  alu_op_t     w_alu_op;
  logic        w_src_a;
  logic        w_src_b;
  pc_sel_t     w_pc_sel;
  wb_sel_t     w_wb_sel;
  logic        w_pc_write;
  logic        w_reg_wr;
  logic        w_mem_req;
  logic        w_instr_req;

  assign w_opcode   = r_ir[6:0];
  assign w_funct3   = r_ir[14:12];
  assign w_funct7b5 = r_ir[30];
  assign w_is_store = (w_opcode == OPC_STORE);
  // BNE/BLT/BLTU are taken on a non-zero ALU result; the others on zero.
  assign w_branch_taken = ALU_Zero_Flag ^ (w_funct3[2] ^ w_funct3[0]);

  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      r_state   <= S_IDLE;
      r_ir      <= RESET_IR;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (Instr_Valid) begin
            r_ir    <= Instruction;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_legal_opcode(w_opcode)) begin
            r_state <= S_EXECUTE;
          end else begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end
        end
        S_EXECUTE: begin
          case (w_opcode)
            OPC_BRANCH, OPC_MISC_MEM: r_state <= S_FETCH;
            OPC_LOAD, OPC_STORE:      r_state <= S_MEMORY;
            default:                  r_state <= S_WRITEBACK;
          endcase
        end
        S_MEMORY: begin
          if (Mem_Ack) r_state <= w_is_store ? S_FETCH : S_WRITEBACK;
        end
        S_WRITEBACK: r_state <= S_FETCH;
        S_TRAP: begin
          r_state   <= S_TRAP;
          r_illegal <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_alu_op    = ALU_ADD;
    w_src_a     = 1'b0;
    w_src_b     = 1'b0;
    w_pc_sel    = PC_PLUS4;
    w_wb_sel    = WB_ALU;
    w_pc_write  = 1'b0;
    w_reg_wr    = 1'b0;
    w_mem_req   = 1'b0;
    w_instr_req = 1'b0;

    // ALU controls are set up in EXECUTE and held through MEMORY/WRITEBACK.
    if (r_state == S_EXECUTE || r_state == S_MEMORY || r_state == S_WRITEBACK) begin
      case (w_opcode)
        OPC_OP:     w_alu_op = alu_from_funct(w_funct3, w_funct7b5, 1'b1);
        OPC_OP_IMM: begin
          w_alu_op = alu_from_funct(w_funct3, w_funct7b5, 1'b0);
          w_src_b  = 1'b1;
        end
        OPC_BRANCH: begin
          case (w_funct3[2:1])
            2'b10:   w_alu_op = ALU_SLT;
            2'b11:   w_alu_op = ALU_SLTU;
            default: w_alu_op = ALU_SUB;
          endcase
        end
        OPC_LOAD, OPC_STORE, OPC_JALR, OPC_LUI: w_src_b = 1'b1;
        OPC_AUIPC, OPC_JAL: begin
          w_src_a = 1'b1;
          w_src_b = 1'b1;
        end
        default: ;
      endcase
    end

    case (r_state)
      S_FETCH: w_instr_req = 1'b1;
      S_EXECUTE: begin
        if (w_opcode == OPC_BRANCH) begin
          w_pc_write = 1'b1;
          w_pc_sel   = w_branch_taken ? PC_IMM : PC_PLUS4;
        end else if (w_opcode == OPC_MISC_MEM) begin
          w_pc_write = 1'b1;
        end
      end
      S_MEMORY: begin
        w_mem_req  = 1'b1;
        w_pc_write = Mem_Ack && w_is_store;
      end
      S_WRITEBACK: begin
        w_reg_wr   = (r_ir[11:7] != 5'd0);
        w_pc_write = 1'b1;
        case (w_opcode)
          OPC_LOAD: w_wb_sel = WB_LOAD;
          OPC_JAL: begin
            w_wb_sel = WB_PC4;
            w_pc_sel = PC_IMM;
          end
          OPC_JALR: begin
            w_wb_sel = WB_PC4;
            w_pc_sel = PC_ALU;
          end
          OPC_LUI:  w_wb_sel = WB_IMM;
          default:  w_wb_sel = WB_ALU;
        endcase
      end
      default: ;
    endcase
  end

  imm_gen #(.DWIDTH(DWIDTH)) u_imm_gen (
    .i_ir  (r_ir),
    .o_imm (Imm)
  );

  assign Instr_Req     = w_instr_req;
  assign Mem_Req       = w_mem_req;
  assign Mem_We        = w_mem_req && w_is_store;
  assign Mem_Size      = w_mem_req ? w_funct3 : 3'b000;
  assign ALU_OP        = w_alu_op;
  assign ALU_Src_A_Sel = w_src_a;
  assign ALU_Src_B_Sel = w_src_b;
  assign PC_Sel        = w_pc_sel;
  assign PC_Write      = w_pc_write;
  assign Rs1_Addr      = r_ir[19:15];
  assign Rs2_Addr      = r_ir[24:20];
  assign Rd_Addr       = r_ir[11:7];
  assign Reg_Wr_En     = w_reg_wr;
  assign Wb_Sel        = w_wb_sel;
  assign Illegal_Instr = r_illegal;

endmodule
